// File: rtl/ysyx_22041071_dmem_resp.sv
// Multi-cycle data-memory responder for the MEM stage: one outstanding load/store,
// bit-masked stores, and a response after a fixed programmable latency.
module ysyx_22041071_dmem_resp #(
  parameter int          DEPTH     = 4096,
  parameter int          IDX_W     = 12,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [63:0] req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam bit         LAT_ONE = (LATENCY == 32'sd1);

  logic [1:0]       state_r;
  logic [3:0]       cnt_r;
  logic             wen_r;
  logic [63:0]      addr_r;
  logic [63:0]      wdata_r;
  logic [63:0]      wmask_r;
  logic             req_ready_r;
  logic             rsp_valid_r;
  logic [63:0]      rsp_rdata_r;
  logic             rsp_err_r;
  logic [63:0]      mem_r [DEPTH];

  logic             accept_s;
  logic             commit_s;
  logic             sel_wen_s;
  logic [63:0]      sel_addr_s;
  logic [63:0]      sel_wdata_s;
  logic [63:0]      sel_wmask_s;
  logic [63:0]      offset_s;
  logic [IDX_W-1:0] idx_s;
  logic             in_range_s;

  assign accept_s = req_valid && req_ready_r;
  // With a one-cycle latency the accepting edge is also the commit edge.
  assign commit_s = (accept_s && LAT_ONE) || ((state_r == WAIT) && (cnt_r == 4'd1));

  // Commit operands come straight from the request port only when committing on acceptance.
  always_comb begin
    sel_wen_s   = wen_r;
    sel_addr_s  = addr_r;
    sel_wdata_s = wdata_r;
    sel_wmask_s = wmask_r;
    if (state_r == IDLE) begin
      sel_wen_s   = req_wen;
      sel_addr_s  = req_addr;
      sel_wdata_s = req_wdata;
      sel_wmask_s = req_wmask;
    end else begin
      sel_wen_s   = wen_r;
      sel_addr_s  = addr_r;
      sel_wdata_s = wdata_r;
      sel_wmask_s = wmask_r;
    end
  end

  assign offset_s   = sel_addr_s - BASE_ADDR;
  assign idx_s      = offset_s[IDX_W+2:3];
  assign in_range_s = (sel_addr_s >= BASE_ADDR) && ((offset_s >> 3) < 64'(DEPTH));

  // Control FSM and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      wen_r       <= 1'b0;
      addr_r      <= 64'd0;
      wdata_r     <= 64'd0;
      wmask_r     <= 64'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 64'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            wen_r       <= req_wen;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            wmask_r     <= req_wmask;
            req_ready_r <= 1'b0;
            if (LAT_ONE) begin
              state_r <= RESP;
            end else begin
              state_r <= WAIT;
              cnt_r   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_r <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
        end
      endcase
      if (commit_s) begin
        rsp_valid_r <= 1'b1;
        rsp_err_r   <= !in_range_s;
        rsp_rdata_r <= (!sel_wen_s && in_range_s) ? mem_r[idx_s] : 64'd0;
      end
    end
  end

  // Storage array: not reset, written only by an in-range store on its commit edge.
  always_ff @(posedge clk) begin
    if (commit_s && sel_wen_s && in_range_s) begin
      mem_r[idx_s] <= (mem_r[idx_s] & ~sel_wmask_s) | (sel_wdata_s & sel_wmask_s);
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_ysyx_22041071_dmem_resp.sv
// Scoreboard bench: a LATENCY=2 responder for functional/backpressure/reset cases
// and a LATENCY=1 responder for back-to-back throughput.
module tb_ysyx_22041071_dmem_resp;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 4096;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] WA    = 64'hA5A5_0000_0000_5A5A;
  localparam logic [63:0] WB    = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] WD    = 64'h1122_3344_5566_7788;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
  logic [63:0] req_addr, req_wdata, req_wmask, rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_wen, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [63:0] b_req_addr, b_req_wdata, b_req_wmask, b_rsp_rdata;

  int   checks;
  int   errors;
  int   ncyc;
  int   b_last;
  exp_t sb_q[$];
  exp_t sb1_q[$];

  ysyx_22041071_dmem_resp #(.LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  ysyx_22041071_dmem_resp #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction on the LATENCY=2 responder; hold = cycles of rsp_ready=0 after rsp_valid.
  task automatic xact(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [63:0] wmask, input logic [63:0] exp_rd, input logic exp_err,
                      input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    sb_q.push_back('{rdata: exp_rd, err: exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("latency", 64'(n), 64'd2);
    e = sb_q.pop_front();
    check_eq("rdata", rsp_rdata, e.rdata);
    check_eq("err", 64'(rsp_err), 64'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 64'(rsp_valid), 64'd1);
      check_eq("bp_rdata", rsp_rdata, e.rdata);
      check_eq("bp_err", 64'(rsp_err), 64'(e.err));
      check_eq("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("hs_valid", 64'(rsp_valid), 64'd0);
    check_eq("hs_err", 64'(rsp_err), 64'd0);
    check_eq("hs_req_ready", 64'(req_ready), 64'd1);
  endtask

  // Response monitor for the LATENCY=1 responder (rsp_ready held high during its test).
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (b_rsp_valid) begin
      check_eq("b_pending", 64'(sb1_q.size() > 0), 64'd1);
      if (sb1_q.size() > 0) begin
        e = sb1_q.pop_front();
        check_eq("b_rdata", b_rsp_rdata, e.rdata);
        check_eq("b_err", 64'(b_rsp_err), 64'(e.err));
      end
      if (b_last >= 0) begin
        check_eq("b_period", 64'(ncyc - b_last), 64'd2);
      end
      b_last = ncyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0; errors = 0; ncyc = 0; b_last = -1;
    reset = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; req_wmask = 64'd0;
    rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_wen = 1'b0; b_req_addr = 64'd0; b_req_wdata = 64'd0;
    b_req_wmask = 64'd0; b_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 64'd0);
    check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Seed word 0, word DEPTH-1 and the byte-merge target.
    xact(1'b1, BASE, WA, ONES, 64'd0, 1'b0, 0);
    xact(1'b1, BASE + 64'(8 * (DEPTH - 1)), WB, ONES, 64'd0, 1'b0, 0);
    xact(1'b1, BASE + 64'h8, ONES, ONES, 64'd0, 1'b0, 0);

    xact(1'b1, BASE + 64'h10, WD, ONES, 64'd0, 1'b0, 0);
    xact(1'b0, BASE + 64'h10, 64'd0, 64'd0, WD, 1'b0, 0);

    xact(1'b1, BASE + 64'h8, 64'h0000_0000_00AB_0000, 64'h0000_0000_00FF_0000, 64'd0, 1'b0, 0);
    xact(1'b0, BASE + 64'h8, 64'd0, 64'd0, 64'hFFFF_FFFF_FFAB_FFFF, 1'b0, 0);

    xact(1'b0, BASE + 64'h10, 64'd0, 64'd0, WD, 1'b0, 5);

    // Out of range on both sides; the high one would alias word 0 if unchecked.
    xact(1'b0, 64'h0000_0000_7FFF_FFF8, 64'd0, 64'd0, 64'd0, 1'b1, 0);
    xact(1'b1, BASE + 64'(8 * DEPTH), 64'hDEAD_BEEF_DEAD_BEEF, ONES, 64'd0, 1'b1, 0);
    xact(1'b0, BASE, 64'd0, 64'd0, WA, 1'b0, 0);
    xact(1'b0, BASE + 64'(8 * (DEPTH - 1)), 64'd0, 64'd0, WB, 1'b0, 0);

    xact(1'b1, BASE + 64'h10, 64'd0, 64'd0, 64'd0, 1'b0, 0);
    xact(1'b0, BASE + 64'h10, 64'd0, 64'd0, WD, 1'b0, 0);

    // Reset while a store sits in WAIT: it must never commit.
    req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE + 64'h10;
    req_wdata = 64'hCAFE_F00D_CAFE_F00D; req_wmask = ONES;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("mid_req_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    #1;
    check_eq("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("mid_rst_req_ready", 64'(req_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("post_rst_req_ready", 64'(req_ready), 64'd1);
    xact(1'b0, BASE + 64'h10, 64'd0, 64'd0, WD, 1'b0, 0);

    // LATENCY=1 back-to-back: 4 stores then 4 loads with rsp_ready tied high.
    b_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!b_req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_eq("b_req_ready", 64'(b_req_ready), 64'd1);
      b_req_valid = 1'b1;
      b_req_wen   = (i < 4);
      b_req_addr  = BASE + 64'h100 + 64'(8 * (i % 4));
      b_req_wdata = 64'hC0DE_0000_0000_0000 | 64'(i % 4 + 1);
      b_req_wmask = ONES;
      if (i < 4) begin
        sb1_q.push_back('{rdata: 64'd0, err: 1'b0});
      end else begin
        sb1_q.push_back('{rdata: 64'hC0DE_0000_0000_0000 | 64'(i - 3), err: 1'b0});
      end
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("b_drain", 64'(sb1_q.size()), 64'd0);
    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
